// File: rtl/cnt_down_pkg.sv
// cnt_down_pkg: shared types and helpers for the four-digit BCD countdown timer.
//   - state_e       : controller states
//   - count_t       : four packed BCD digits, [0] = ones, [3] = thousands
//   - bcd_step      : +/-1 at a chosen digit position, wrapping modulo 10000
//   - seg7_decode   : BCD digit to active-low cathodes {dp,g,f,e,d,c,b,a}
//   - anode_pattern : scan index to active-low anode enables
//   - SEG_RESET     : display word after reset (digit 0 showing "0")
package cnt_down_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [BCD_W-1:0]                  bcd_t;
  typedef logic [NUM_DIGITS-1:0][BCD_W-1:0]  count_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Event vector bit positions, lowest priority first.
  localparam int unsigned EV_D = 0;
  localparam int unsigned EV_U = 1;
  localparam int unsigned EV_L = 2;
  localparam int unsigned EV_R = 3;
  localparam int unsigned EV_C = 4;

  localparam logic [7:0]  SEG_BLANK = 8'hFF;
  localparam logic [11:0] SEG_RESET = 12'hEC0;

  // Ripple a +1/-1 from digit 'pos' upward; the carry/borrow out of the
  // thousands digit is dropped, giving modulo-10000 behaviour.
  function automatic count_t bcd_step(input count_t c, input int unsigned pos,
                                      input logic down);
    count_t r;
    logic   carry;
    r     = c;
    carry = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (i >= pos && carry) begin
        if (!down) begin
          if (r[i] == bcd_t'(9)) begin
            r[i] = '0;
          end else begin
            r[i]  = r[i] + bcd_t'(1);
            carry = 1'b0;
          end
        end else begin
          if (r[i] == bcd_t'(0)) begin
            r[i] = bcd_t'(9);
          end else begin
            r[i]  = r[i] - bcd_t'(1);
            carry = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] seg7_decode(input bcd_t d);
    logic [7:0] s;
    unique case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] anode_pattern(input logic [1:0] idx);
    logic [3:0] a;
    unique case (idx)
      2'd0:    a = 4'b1110;
      2'd1:    a = 4'b1101;
      2'd2:    a = 4'b1011;
      default: a = 4'b0111;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cnt_down_timer_if.sv
// cnt_down_timer_if: board-level I/O bundle of the countdown timer.
//   btnu/btnl/btnc/btnr/btnd : raw push-buttons
//   seg[11:0]                : anodes [11:8] and cathodes [7:0], active-low
//   led                      : completion indicator
// master = button/display side (board or bench), slave = timer side.
interface cnt_down_timer_if;
  logic        btnu;
  logic        btnl;
  logic        btnc;
  logic        btnr;
  logic        btnd;
  logic [11:0] seg;
  logic        led;

  modport master (output btnu, btnl, btnc, btnr, btnd, input seg, led);
  modport slave  (input btnu, btnl, btnc, btnr, btnd, output seg, led);
endinterface

// File: rtl/cnt_down_timer_btn_cond.sv
// btn_cond: conditions one push-button into a single-cycle press event.
//   clk, rst_n : clock, synchronous active-low reset
//   btn_i      : raw asynchronous button
//   evt_o      : registered one-cycle pulse per press
// Chain: 2-flop synchronizer -> optional debounce filter -> rising-edge
// detect -> registered event. The filter is compiled in when
// CNT_DOWN_DEBOUNCE_EN is defined.
module btn_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic evt_o
);

  // Zero would make the filter terminal count underflow.
  if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
    $error("btn_cond: DEBOUNCE_CYCLES must be nonzero");
  end

  logic sync1_q, sync2_q;
  logic lvl;
  logic lvl_prev_q, lvl_prev_d;
  logic evt_q, evt_d;

`ifdef CNT_DOWN_DEBOUNCE_EN
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            filt_q, filt_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  // Any return to the filtered level restarts the stability count.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  always_comb begin
    lvl_prev_d = lvl;
    evt_d      = lvl & ~lvl_prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_prev_q <= 1'b0;
      evt_q      <= 1'b0;
    end else begin
      sync1_q    <= btn_i;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl_prev_d;
      evt_q      <= evt_d;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/cnt_down_timer.sv
// cnt_down_timer: four-digit BCD countdown timer with button control and a
// time-multiplexed seven-segment display.
//   CLK              : system clock, rising edge
//   RESET            : synchronous, active-low
//   BTNU/BTND        : preset +10 / -10 (IDLE only)
//   BTNR/BTNL        : preset +1 / -1 (IDLE only)
//   BTNC             : start / pause / resume / acknowledge
//   SEG[11:0]        : [11:8] anodes ([8] rightmost), [7:0] {dp,g..a}, active-low
//   LED              : high while in DONE
// Parameters: TICK_DIV cycles per decrement, SCAN_DIV cycles per digit slot,
// DEBOUNCE_CYCLES filter length when CNT_DOWN_DEBOUNCE_EN is defined.
module cnt_down_timer
  import cnt_down_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 100_000_000,
  parameter int unsigned SCAN_DIV        = 100_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BTNU,
  input  logic        BTNL,
  input  logic        BTNC,
  input  logic        BTNR,
  input  logic        BTND,
  output logic [11:0] SEG,
  output logic        LED
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // ---------------- button conditioning ----------------
  logic [4:0] btn_raw;
  logic [4:0] evt;

  assign btn_raw[EV_D] = BTND;
  assign btn_raw[EV_U] = BTNU;
  assign btn_raw[EV_L] = BTNL;
  assign btn_raw[EV_R] = BTNR;
  assign btn_raw[EV_C] = BTNC;

  for (genvar g = 0; g < 5; g++) begin : g_btn
    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_cond (
      .clk   (CLK),
      .rst_n (RESET),
      .btn_i (btn_raw[g]),
      .evt_o (evt[g])
    );
  end

  // ---------------- state ----------------
  state_e             state_q, state_d;
  count_t             count_q, count_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         scan_idx_q, scan_idx_d;
  logic [11:0]        seg_q, seg_d;
  logic               led_q, led_d;

  logic tick_wrap;
  assign tick_wrap = (tick_q == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // BTNC outranks every edit button, so a coincident edit is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (evt[EV_C] && count_q != '0) state_d = ST_RUN;
      ST_RUN: begin
        if (evt[EV_C]) begin
          state_d = ST_PAUSE;
        end else if (tick_wrap && count_q == count_t'(16'h0001)) begin
          state_d = ST_DONE;
        end
      end
      ST_PAUSE: if (evt[EV_C]) state_d = ST_RUN;
      ST_DONE:  if (evt[EV_C]) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // LED follows the next state so it rises on the edge the count hits zero.
  always_comb begin
    led_d = (state_d == ST_DONE);
  end

  // ---------------- count and tick datapath ----------------
  always_comb begin
    count_d = count_q;
    tick_d  = tick_q;
    unique case (state_q)
      ST_IDLE: begin
        // Held at zero so RUN always starts a full tick period.
        tick_d = '0;
        if (!evt[EV_C]) begin
          if (evt[EV_R])      count_d = bcd_step(count_q, 0, 1'b0);
          else if (evt[EV_L]) count_d = bcd_step(count_q, 0, 1'b1);
          else if (evt[EV_U]) count_d = bcd_step(count_q, 1, 1'b0);
          else if (evt[EV_D]) count_d = bcd_step(count_q, 1, 1'b1);
        end
      end
      ST_RUN: begin
        // The pause cycle itself does not advance the tick, so resume
        // continues from exactly the phase that was frozen.
        if (!evt[EV_C]) begin
          if (tick_wrap) begin
            tick_d  = '0;
            count_d = bcd_step(count_q, 0, 1'b1);
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------- display scan ----------------
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_idx_d = scan_idx_q + 2'd1;
    end
    seg_d = {anode_pattern(scan_idx_q), seg7_decode(count_q[scan_idx_q])};
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      count_q    <= '0;
      tick_q     <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      seg_q      <= SEG_RESET;
      led_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      tick_q     <= tick_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      seg_q      <= seg_d;
      led_q      <= led_d;
    end
  end

  assign SEG = seg_q;
  assign LED = led_q;

endmodule

// File: tb/tb_cnt_down_timer.sv
// tb_cnt_down_timer: directed self-checking bench for cnt_down_timer with
// TICK_DIV = 50, SCAN_DIV = 4. The count is read back by scanning the display.
module tb_cnt_down_timer;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  logic [4:0] btn = '0;   // {C,R,L,U,D}

  localparam logic [4:0] B_D = 5'b00001;
  localparam logic [4:0] B_U = 5'b00010;
  localparam logic [4:0] B_L = 5'b00100;
  localparam logic [4:0] B_R = 5'b01000;
  localparam logic [4:0] B_C = 5'b10000;

  always #5 CLK = ~CLK;

  cnt_down_timer_if bif ();

  assign bif.btnd = btn[0];
  assign bif.btnu = btn[1];
  assign bif.btnl = btn[2];
  assign bif.btnr = btn[3];
  assign bif.btnc = btn[4];

  cnt_down_timer #(
    .TICK_DIV        (50),
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .BTNU  (bif.btnu),
    .BTNL  (bif.btnl),
    .BTNC  (bif.btnc),
    .BTNR  (bif.btnr),
    .BTND  (bif.btnd),
    .SEG   (bif.seg),
    .LED   (bif.led)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] seg2dig(input logic [7:0] c);
    case (c)
      8'hC0:   return 4'd0;
      8'hF9:   return 4'd1;
      8'hA4:   return 4'd2;
      8'hB0:   return 4'd3;
      8'h99:   return 4'd4;
      8'h92:   return 4'd5;
      8'h82:   return 4'd6;
      8'hF8:   return 4'd7;
      8'h80:   return 4'd8;
      8'h90:   return 4'd9;
      default: return 4'hF;
    endcase
  endfunction

  // Two-cycle press followed by 'gap' low cycles; returns on a falling edge.
  task automatic pulse(input logic [4:0] mask, input int unsigned gap);
    @(negedge CLK);
    btn = mask;
    repeat (2) @(negedge CLK);
    btn = '0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic pulses(input logic [4:0] mask, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) pulse(mask, 20);
  endtask

  // Scan the display until all four slots are seen (bounded).
  task automatic read_disp(input string tag, output logic [15:0] val,
                           output logic [7:0] c0, output logic [7:0] c1);
    logic [7:0] cath [4];
    logic [3:0] seen;
    seen = '0;
    for (int i = 0; i < 4; i++) cath[i] = 8'h00;
    for (int i = 0; i < 64 && seen != 4'hF; i++) begin
      @(negedge CLK);
      case (bif.seg[11:8])
        4'b1110: begin cath[0] = bif.seg[7:0]; seen[0] = 1'b1; end
        4'b1101: begin cath[1] = bif.seg[7:0]; seen[1] = 1'b1; end
        4'b1011: begin cath[2] = bif.seg[7:0]; seen[2] = 1'b1; end
        4'b0111: begin cath[3] = bif.seg[7:0]; seen[3] = 1'b1; end
        default: ;
      endcase
    end
    check({tag, "_scan"}, 32'(seen), 32'hF);
    val = {seg2dig(cath[3]), seg2dig(cath[2]), seg2dig(cath[1]), seg2dig(cath[0])};
    c0  = cath[0];
    c1  = cath[1];
  endtask

  task automatic expect_count(input string tag, input logic [15:0] exp);
    logic [15:0] v;
    logic [7:0]  c0, c1;
    read_disp(tag, v, c0, c1);
    check(tag, 32'(v), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic [7:0]  c0, c1;
    bit          done_seen;

    // 1. reset
    RESET = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    check("rst_seg", 32'(bif.seg), 32'hEC0);
    check("rst_led", 32'(bif.led), 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    expect_count("rst_count", 16'h0000);

    // 2. eleven +1 presses
    pulses(B_R, 11);
    read_disp("inc11", v, c0, c1);
    check("inc11_count", 32'(v), 32'h0011);
    check("inc11_dig0", 32'(c0), 32'hF9);
    check("inc11_dig1", 32'(c1), 32'hF9);

    // 3. run to zero; press high at edge N, RUN at N+3, 11th decrement at N+553
    pulse(B_C, 0);
    repeat (551) @(posedge CLK);
    #1;
    check("done_led_early", 32'(bif.led), 32'h0);
    @(posedge CLK);
    #1;
    check("done_led_edge", 32'(bif.led), 32'h1);
    expect_count("done_count", 16'h0000);
    pulse(B_C, 20);
    check("ack_led", 32'(bif.led), 32'h0);

    // 4. wrap boundaries
    pulse(B_L, 20); expect_count("dec1_wrap", 16'h9999);
    pulse(B_R, 20); expect_count("inc1_wrap", 16'h0000);
    pulse(B_D, 20); expect_count("dec10_wrap", 16'h9990);
    pulse(B_U, 20); expect_count("inc10_wrap", 16'h0000);
    pulses(B_R, 3);
    pulse(B_D, 20); expect_count("dec10_0003", 16'h9993);
    pulse(B_U, 20); expect_count("inc10_9993", 16'h0003);
    pulses(B_L, 3); expect_count("dec1_to0", 16'h0000);

    // priority: R over L; L over U and D
    pulse(B_R | B_L, 20);       expect_count("prio_r_l", 16'h0001);
    pulse(B_L | B_U | B_D, 20); expect_count("prio_l_ud", 16'h0000);

    // long hold counts once
    @(negedge CLK);
    btn = B_R;
    repeat (40) @(negedge CLK);
    btn = '0;
    repeat (20) @(negedge CLK);
    expect_count("hold_once", 16'h0001);

    // 5. pause at 0005: from 0008, count is 5 between N+153 and N+203
    pulses(B_R, 7);
    pulse(B_C, 0);
    repeat (158) @(posedge CLK);
    pulse(B_C, 0);
    repeat (200) @(negedge CLK);
    expect_count("pause_hold", 16'h0005);
    check("pause_led", 32'(bif.led), 32'h0);
    pulse(B_R, 20);
    expect_count("pause_no_edit", 16'h0005);
    pulse(B_C, 0);
    done_seen = 1'b0;
    for (int i = 0; i < 400 && !done_seen; i++) begin
      @(negedge CLK);
      if (bif.led) done_seen = 1'b1;
    end
    check("resume_done", 32'(done_seen), 32'h1);
    expect_count("resume_count", 16'h0000);
    pulse(B_C, 20);

    // 6. reset in RUN
    pulses(B_R, 5);
    pulse(B_C, 30);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    check("midrst_seg", 32'(bif.seg), 32'hEC0);
    check("midrst_led", 32'(bif.led), 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    expect_count("midrst_count", 16'h0000);
    pulse(B_C, 200);
    expect_count("start_zero_ignored", 16'h0000);
    check("start_zero_led", 32'(bif.led), 32'h0);
    pulses(B_R, 5);
    expect_count("post_rst_inc5", 16'h0005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
